rob: RTL

- 32-entry, 2-wide in-order reorder buffer.
- Accepts up to two renamed instructions per cycle at dispatch. Each carries a new tag T, an old tag Told and an architectural destination.
- Marks entries complete from two writeback ports.
- Retires up to two completed instructions per cycle in program order and hands their Told tags back to the free list as rob_Told_1/2 with R_en_1/2.
- Squashes younger entries on a branch mispredict.

---
 rtl/rob.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/rob.sv
// 2-wide in-order reorder buffer: dual dispatch, dual completion, dual in-order retire,
// and squash of everything younger than a mispredicted branch.
`ifndef ZERO_REG
`define ZERO_REG 6'd0
`endif

module rob #(
    parameter  int ROB_DEPTH = 32,
    localparam int IW        = $clog2(ROB_DEPTH),
    localparam int PW        = IW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          D_en_1,
    input  logic          D_en_2,
    input  logic [5:0]    id_T_1,
    input  logic [5:0]    id_T_2,
    input  logic [5:0]    id_Told_1,
    input  logic [5:0]    id_Told_2,
    input  logic [4:0]    id_ard_1,
    input  logic [4:0]    id_ard_2,
    input  logic          cdb_en_1,
    input  logic          cdb_en_2,
    input  logic [IW-1:0] cdb_rob_idx_1,
    input  logic [IW-1:0] cdb_rob_idx_2,
    input  logic          br_mispredict,
    input  logic [IW-1:0] br_rob_idx,
    output logic [IW-1:0] rob_idx_1,
    output logic [IW-1:0] rob_idx_2,
    output logic          R_en_1,
    output logic          R_en_2,
    output logic [5:0]    rob_Told_1,
    output logic [5:0]    rob_Told_2,
    output logic [5:0]    rob_T_1,
    output logic [5:0]    rob_T_2,
    output logic [4:0]    rob_ard_1,
    output logic [4:0]    rob_ard_2,
    output logic [1:0]    rob_stall
);

    logic [ROB_DEPTH-1:0] valid_q, valid_d;
    logic [ROB_DEPTH-1:0] complete_q, complete_d;
    logic [5:0]           t_q    [ROB_DEPTH];
    logic [5:0]           t_d    [ROB_DEPTH];
    logic [5:0]           told_q [ROB_DEPTH];
    logic [5:0]           told_d [ROB_DEPTH];
    logic [4:0]           ard_q  [ROB_DEPTH];
    logic [4:0]           ard_d  [ROB_DEPTH];
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;

    logic [PW-1:0]        count;
    logic [IW-1:0]        head_idx, head_nxt_idx;
    logic [IW-1:0]        tail_idx, tail_nxt_idx;
    logic                 acc_1, acc_2;
    logic                 ret_1, ret_2;
    logic [IW-1:0]        br_off;
    logic [PW-1:0]        br_ptr;

    assign count        = tail_q - head_q;
    assign head_idx     = head_q[IW-1:0];
    assign head_nxt_idx = head_idx + IW'(1);
    assign tail_idx     = tail_q[IW-1:0];
    assign tail_nxt_idx = tail_idx + IW'(1);

    // Branch position expressed as a full pointer so the restored tail keeps
    // a wrap bit consistent with head.
    assign br_off = br_rob_idx - head_idx;
    assign br_ptr = head_q + PW'(br_off);

    always_comb begin
        acc_1 = D_en_1 && !br_mispredict && (count < PW'(ROB_DEPTH));
        acc_2 = D_en_2 && !br_mispredict &&
                ((count + PW'(acc_1)) < PW'(ROB_DEPTH));
    end

    always_comb begin
        ret_1 = valid_q[head_idx] & complete_q[head_idx];
        ret_2 = ret_1 & valid_q[head_nxt_idx] & complete_q[head_nxt_idx];
    end

    always_comb begin
        logic [IW-1:0] age;
        age        = '0;
        valid_d    = valid_q;
        complete_d = complete_q;
        t_d        = t_q;
        told_d     = told_q;
        ard_d      = ard_q;

        if (cdb_en_1 && valid_q[cdb_rob_idx_1]) complete_d[cdb_rob_idx_1] = 1'b1;
        if (cdb_en_2 && valid_q[cdb_rob_idx_2]) complete_d[cdb_rob_idx_2] = 1'b1;

        if (ret_1) begin
            valid_d[head_idx]    = 1'b0;
            complete_d[head_idx] = 1'b0;
        end
        if (ret_2) begin
            valid_d[head_nxt_idx]    = 1'b0;
            complete_d[head_nxt_idx] = 1'b0;
        end

        // Squash runs after completion so late writebacks cannot revive younger entries.
        if (br_mispredict) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                age = IW'(i) - head_idx;
                if (age > br_off) begin
                    valid_d[i]    = 1'b0;
                    complete_d[i] = 1'b0;
                end
            end
        end

        if (acc_1) begin
            valid_d[tail_idx]    = 1'b1;
            complete_d[tail_idx] = 1'b0;
            t_d[tail_idx]        = id_T_1;
            told_d[tail_idx]     = id_Told_1;
            ard_d[tail_idx]      = id_ard_1;
        end
        if (acc_2) begin
            valid_d[rob_idx_2]    = 1'b1;
            complete_d[rob_idx_2] = 1'b0;
            t_d[rob_idx_2]        = id_T_2;
            told_d[rob_idx_2]     = id_Told_2;
            ard_d[rob_idx_2]      = id_ard_2;
        end
    end

    always_comb begin
        head_d = head_q + PW'(ret_1) + PW'(ret_2);
        if (br_mispredict) begin
            tail_d = br_ptr + PW'(1);
        end else begin
            tail_d = tail_q + PW'(acc_1) + PW'(acc_2);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            valid_q    <= '0;
            complete_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            valid_q    <= valid_d;
            complete_q <= complete_d;
        end
    end

    // Payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clock) begin
        t_q    <= t_d;
        told_q <= told_d;
        ard_q  <= ard_d;
    end

    always_comb begin
        rob_idx_1  = tail_idx;
        rob_idx_2  = D_en_1 ? tail_nxt_idx : tail_idx;
        R_en_1     = ret_1;
        R_en_2     = ret_2;
        rob_Told_1 = ret_1 ? told_q[head_idx]     : `ZERO_REG;
        rob_Told_2 = ret_2 ? told_q[head_nxt_idx] : `ZERO_REG;
        rob_T_1    = ret_1 ? t_q[head_idx]        : `ZERO_REG;
        rob_T_2    = ret_2 ? t_q[head_nxt_idx]    : `ZERO_REG;
        rob_ard_1  = ret_1 ? ard_q[head_idx]      : 5'd0;
        rob_ard_2  = ret_2 ? ard_q[head_nxt_idx]  : 5'd0;
        if (count == PW'(ROB_DEPTH)) begin
            rob_stall = 2'b11;
        end else if (count == PW'(ROB_DEPTH - 1)) begin
            rob_stall = 2'b01;
        end else begin
            rob_stall = 2'b00;
        end
    end

endmodule
